// File: rtl/hp_pkg.sv
// Purpose: shared state encoding, HP code constants and thresholds for the HP drain block and bar lookup.
// Latency: n/a (declarations and a pure combinational helper only).
// Backpressure: n/a.
package hp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FAINT = 2'd2
    } hp_state_t;

    // Codes decoded by the bar-width lookup; FULL is deliberately 0 so a
    // cleared register reads as a full bar.
    localparam logic [7:0] HP_CODE_FULL = 8'h00;
    localparam logic [7:0] HP_CODE_MID  = 8'h53;
    localparam logic [7:0] HP_CODE_LOW  = 8'h35;
    localparam logic [7:0] HP_CODE_MIN  = 8'h07;

    // Lower bound (inclusive) of each code band.
    localparam logic [5:0] HP_THR_FULL = 6'd48;
    localparam logic [5:0] HP_THR_MID  = 6'd24;
    localparam logic [5:0] HP_THR_LOW  = 6'd12;

    function automatic logic [7:0] hp_to_code(input logic [5:0] hp);
        if (hp >= HP_THR_FULL)     return HP_CODE_FULL;
        else if (hp >= HP_THR_MID) return HP_CODE_MID;
        else if (hp >= HP_THR_LOW) return HP_CODE_LOW;
        else                       return HP_CODE_MIN;
    endfunction

endpackage

// File: rtl/hp_code_map.sv
// Purpose: registers the bar-lookup HP code and the fainted flag from the current HP.
// Latency: 1 cycle from i_hp to o_hp_code / o_fainted.
// Backpressure: none; updates every cycle.
// Ports: i_clk, i_reset (sync, active-high), i_hp (6b) in; o_hp_code (8b), o_fainted out.
module hp_code_map
    import hp_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [5:0] i_hp,
    output logic [7:0] o_hp_code,
    output logic       o_fainted
);

    logic [7:0] r_hp_code;
    logic       r_fainted;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hp_code <= HP_CODE_FULL;
            r_fainted <= 1'b0;
        end else begin
            r_hp_code <= hp_to_code(i_hp);
            r_fainted <= (i_hp == 6'd0);
        end
    end

    assign o_hp_code = r_hp_code;
    assign o_fainted = r_fainted;

endmodule

// File: rtl/hp_drain_encoder.sv
// Purpose: holds HP, accepts damage/restore, drains HP one point per DRAIN_DIV cycles, emits bar code.
// Latency: first decrement DRAIN_DIV+1 cycles after accept; d-point drain done d*DRAIN_DIV+1 cycles after accept.
// Backpressure: o_hit_ready low outside IDLE or while restore is asserted; unaccepted hits are dropped.
// Ports: i_clk, i_reset (sync, active-high), i_hit_valid, i_hit_dmg (6b), i_restore in;
//        o_hit_ready (comb), o_hp (6b), o_hp_code (8b), o_drain_done, o_fainted out.
module hp_drain_encoder
    import hp_pkg::*;
#(
    parameter int HP_MAX    = 63,
    parameter int DRAIN_DIV = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_hit_valid,
    input  logic [5:0] i_hit_dmg,
    output logic       o_hit_ready,
    input  logic       i_restore,
    output logic [5:0] o_hp,
    output logic [7:0] o_hp_code,
    output logic       o_drain_done,
    output logic       o_fainted
);

    localparam logic [5:0] HP_MAX_V = 6'(HP_MAX);
    localparam logic [7:0] DIV_LAST = 8'(DRAIN_DIV - 1);

    hp_state_t  r_state;
    logic [5:0] r_hp;
    logic [5:0] r_target;
    logic [7:0] r_div;
    logic       r_drain_done;

    hp_state_t  w_state_nxt;
    logic [5:0] w_hp_nxt;
    logic [5:0] w_target_nxt;
    logic [7:0] w_div_nxt;
    logic       w_done_nxt;
    logic [5:0] w_hp_dec;
    logic [5:0] w_hit_target;

    assign w_hp_dec = r_hp - 6'd1;

    // Widened compare so a hit larger than current HP clamps to 0 instead of wrapping.
    assign w_hit_target = ({1'b0, r_hp} > {1'b0, i_hit_dmg}) ? (r_hp - i_hit_dmg) : 6'd0;

    assign o_hit_ready = (r_state == IDLE) && !i_restore;

    always_comb begin
        w_state_nxt  = r_state;
        w_hp_nxt     = r_hp;
        w_target_nxt = r_target;
        w_div_nxt    = r_div;
        w_done_nxt   = 1'b0;

        if (i_restore) begin
            // Restore overrides everything, including an in-flight drain, and never signals done.
            w_state_nxt = IDLE;
            w_hp_nxt    = HP_MAX_V;
            w_div_nxt   = 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_hit_valid) begin
                        w_target_nxt = w_hit_target;
                        w_div_nxt    = 8'd0;
                        w_state_nxt  = DRAIN;
                    end
                end
                DRAIN: begin
                    if (r_hp == r_target) begin
                        // Only reachable on a zero-damage hit: finish without decrementing.
                        w_done_nxt  = 1'b1;
                        w_state_nxt = (r_target == 6'd0) ? FAINT : IDLE;
                    end else if (r_div == DIV_LAST) begin
                        w_div_nxt = 8'd0;
                        w_hp_nxt  = w_hp_dec;
                        // Exit on the same edge as the final decrement so done aligns with the last hp value.
                        if (w_hp_dec == r_target) begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = (r_target == 6'd0) ? FAINT : IDLE;
                        end
                    end else begin
                        w_div_nxt = r_div + 8'd1;
                    end
                end
                FAINT: begin
                    w_state_nxt = FAINT;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_hp         <= HP_MAX_V;
            r_target     <= HP_MAX_V;
            r_div        <= 8'd0;
            r_drain_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_hp         <= w_hp_nxt;
            r_target     <= w_target_nxt;
            r_div        <= w_div_nxt;
            r_drain_done <= w_done_nxt;
        end
    end

    hp_code_map u_code_map (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_hp      (r_hp),
        .o_hp_code (o_hp_code),
        .o_fainted (o_fainted)
    );

    assign o_hp         = r_hp;
    assign o_drain_done = r_drain_done;

endmodule

// File: tb/tb_hp_drain_encoder.sv
module tb_hp_drain_encoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       hit_valid;
    logic [5:0] hit_dmg;
    logic       restore;
    logic       hit_ready;
    logic [5:0] hp;
    logic [7:0] hp_code;
    logic       drain_done;
    logic       fainted;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hp_drain_encoder #(.HP_MAX(63), .DRAIN_DIV(4)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_hit_valid  (hit_valid),
        .i_hit_dmg    (hit_dmg),
        .o_hit_ready  (hit_ready),
        .i_restore    (restore),
        .o_hp         (hp),
        .o_hp_code    (hp_code),
        .o_drain_done (drain_done),
        .o_fainted    (fainted)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_code(input int h);
        if (h >= 48)      return 8'h00;
        else if (h >= 24) return 8'h53;
        else if (h >= 12) return 8'h35;
        else              return 8'h07;
    endfunction

    task automatic test_reset;
        reset = 1'b1; hit_valid = 1'b0; hit_dmg = 6'd0; restore = 1'b0;
        tick; tick;
        reset = 1'b0;
        #1;
        checks++; if (hp !== 6'd63) begin errors++; $display("FAIL reset_hp: got %0d expected 63", hp); end
        checks++; if (hp_code !== 8'h00) begin errors++; $display("FAIL reset_code: got %h expected 00", hp_code); end
        checks++; if (fainted !== 1'b0) begin errors++; $display("FAIL reset_fainted: got %b expected 0", fainted); end
        checks++; if (hit_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", hit_ready); end
        checks++; if (drain_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", drain_done); end
    endtask

    // hp 63 -> 43, one step every 4 cycles, done 81 cycles after accept.
    task automatic test_normal_drain;
        int eh;
        int prev;
        hit_dmg = 6'd20; hit_valid = 1'b1;
        tick;
        hit_valid = 1'b0;
        prev = 63;
        for (int k = 1; k <= 82; k++) begin
            eh = 63 - (k - 1) / 4;
            if (eh < 43) eh = 43;
            checks++; if (hp !== 6'(eh)) begin errors++; $display("FAIL drain_hp k=%0d: got %0d expected %0d", k, hp, eh); end
            checks++; if (drain_done !== (k == 81)) begin errors++; $display("FAIL drain_done k=%0d: got %b expected %b", k, drain_done, (k == 81)); end
            checks++; if (hp_code !== exp_code(prev)) begin errors++; $display("FAIL drain_code k=%0d: got %h expected %h", k, hp_code, exp_code(prev)); end
            if (k <= 80) begin
                checks++; if (hit_ready !== 1'b0) begin errors++; $display("FAIL drain_ready k=%0d: got %b expected 0", k, hit_ready); end
            end
            if (k == 82) begin
                checks++; if (hit_ready !== 1'b1) begin errors++; $display("FAIL drain_ready_after: got %b expected 1", hit_ready); end
            end
            prev = eh;
            if (k < 82) tick;
        end
    endtask

    // hp 43 hit for 50 saturates at 0; hits during DRAIN and FAINT are dropped.
    task automatic test_saturating_ignored;
        int eh;
        int prev;
        hit_dmg = 6'd50; hit_valid = 1'b1;
        tick;
        hit_valid = 1'b0;
        prev = 43;
        for (int k = 1; k <= 180; k++) begin
            eh = 43 - (k - 1) / 4;
            if (eh < 0) eh = 0;
            checks++; if (hp !== 6'(eh)) begin errors++; $display("FAIL sat_hp k=%0d: got %0d expected %0d", k, hp, eh); end
            checks++; if (drain_done !== (k == 173)) begin errors++; $display("FAIL sat_done k=%0d: got %b expected %b", k, drain_done, (k == 173)); end
            checks++; if (hp_code !== exp_code(prev)) begin errors++; $display("FAIL sat_code k=%0d: got %h expected %h", k, hp_code, exp_code(prev)); end
            checks++; if (fainted !== (prev == 0)) begin errors++; $display("FAIL sat_fainted k=%0d: got %b expected %b", k, fainted, (prev == 0)); end
            checks++; if (hit_ready !== 1'b0) begin errors++; $display("FAIL sat_ready k=%0d: got %b expected 0", k, hit_ready); end
            // Stray hits while draining and while fainted.
            hit_valid = ((k >= 10) && (k <= 12)) || (k >= 174);
            hit_dmg   = (k >= 174) ? 6'd0 : 6'd1;
            prev = eh;
            if (k < 180) tick;
        end
        hit_valid = 1'b0;
    endtask

    task automatic test_restore;
        // Restore out of FAINT.
        restore = 1'b1;
        tick;
        restore = 1'b0;
        #1;
        checks++; if (hp !== 6'd63) begin errors++; $display("FAIL rst_faint_hp: got %0d expected 63", hp); end
        checks++; if (hit_ready !== 1'b1) begin errors++; $display("FAIL rst_faint_ready: got %b expected 1", hit_ready); end
        checks++; if (hp_code !== 8'h07) begin errors++; $display("FAIL rst_faint_code_lag: got %h expected 07", hp_code); end
        checks++; if (fainted !== 1'b1) begin errors++; $display("FAIL rst_faint_fainted_lag: got %b expected 1", fainted); end
        tick;
        checks++; if (hp_code !== 8'h00) begin errors++; $display("FAIL rst_faint_code: got %h expected 00", hp_code); end
        checks++; if (fainted !== 1'b0) begin errors++; $display("FAIL rst_faint_fainted: got %b expected 0", fainted); end
        // Restore mid-drain.
        hit_dmg = 6'd30; hit_valid = 1'b1;
        tick;
        hit_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick;
        checks++; if (hp !== 6'd61) begin errors++; $display("FAIL rst_mid_before: got %0d expected 61", hp); end
        restore = 1'b1;
        tick;
        restore = 1'b0;
        #1;
        checks++; if (hp !== 6'd63) begin errors++; $display("FAIL rst_mid_hp: got %0d expected 63", hp); end
        checks++; if (hit_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b expected 1", hit_ready); end
        for (int i = 0; i < 10; i++) begin
            checks++; if (drain_done !== 1'b0) begin errors++; $display("FAIL rst_mid_done i=%0d: got %b expected 0", i, drain_done); end
            checks++; if (hp !== 6'd63) begin errors++; $display("FAIL rst_mid_hold i=%0d: got %0d expected 63", i, hp); end
            tick;
        end
        checks++; if (hp_code !== 8'h00) begin errors++; $display("FAIL rst_mid_code: got %h expected 00", hp_code); end
    endtask

    task automatic test_simultaneous;
        restore = 1'b1; hit_valid = 1'b1; hit_dmg = 6'd10;
        #1;
        checks++; if (hit_ready !== 1'b0) begin errors++; $display("FAIL simul_ready_comb: got %b expected 0", hit_ready); end
        tick;
        restore = 1'b0; hit_valid = 1'b0;
        #1;
        checks++; if (hit_ready !== 1'b1) begin errors++; $display("FAIL simul_not_accepted: got %b expected 1", hit_ready); end
        for (int i = 0; i < 6; i++) begin
            tick;
            checks++; if (hp !== 6'd63) begin errors++; $display("FAIL simul_hp i=%0d: got %0d expected 63", i, hp); end
        end
    endtask

    task automatic test_zero_hit;
        hit_dmg = 6'd0; hit_valid = 1'b1;
        tick;
        hit_valid = 1'b0;
        checks++; if (drain_done !== 1'b0) begin errors++; $display("FAIL zero_done_k1: got %b expected 0", drain_done); end
        checks++; if (hit_ready !== 1'b0) begin errors++; $display("FAIL zero_ready_k1: got %b expected 0", hit_ready); end
        tick;
        checks++; if (drain_done !== 1'b1) begin errors++; $display("FAIL zero_done_k2: got %b expected 1", drain_done); end
        checks++; if (hp !== 6'd63) begin errors++; $display("FAIL zero_hp_k2: got %0d expected 63", hp); end
        tick;
        checks++; if (drain_done !== 1'b0) begin errors++; $display("FAIL zero_done_k3: got %b expected 0", drain_done); end
        checks++; if (hit_ready !== 1'b1) begin errors++; $display("FAIL zero_ready_k3: got %b expected 1", hit_ready); end
        checks++; if (hp !== 6'd63) begin errors++; $display("FAIL zero_hp_k3: got %0d expected 63", hp); end
    endtask

    task automatic test_reset_mid_drain;
        hit_dmg = 6'd60; hit_valid = 1'b1;
        tick;
        hit_valid = 1'b0;
        for (int i = 0; i < 69; i++) tick;
        checks++; if (hp !== 6'd46) begin errors++; $display("FAIL rmd_before_hp: got %0d expected 46", hp); end
        checks++; if (hp_code !== 8'h53) begin errors++; $display("FAIL rmd_before_code: got %h expected 53", hp_code); end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        #1;
        checks++; if (hp !== 6'd63) begin errors++; $display("FAIL rmd_hp: got %0d expected 63", hp); end
        checks++; if (hp_code !== 8'h00) begin errors++; $display("FAIL rmd_code: got %h expected 00", hp_code); end
        checks++; if (fainted !== 1'b0) begin errors++; $display("FAIL rmd_fainted: got %b expected 0", fainted); end
        checks++; if (drain_done !== 1'b0) begin errors++; $display("FAIL rmd_done: got %b expected 0", drain_done); end
        checks++; if (hit_ready !== 1'b1) begin errors++; $display("FAIL rmd_ready: got %b expected 1", hit_ready); end
        for (int i = 0; i < 8; i++) tick;
        checks++; if (hp !== 6'd63) begin errors++; $display("FAIL rmd_hold: got %0d expected 63", hp); end
    endtask

    initial begin
        test_reset;
        test_normal_drain;
        test_saturating_ignored;
        test_restore;
        test_simultaneous;
        test_zero_hit;
        test_reset_mid_drain;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
